// File: rtl/m_stage_mem_ctrl_pkg.sv
// Shared definitions for the memory-stage controller: size codes,
// exception codes, FSM state encoding and the alignment rule.
`timescale 1ns/1ps
package m_stage_mem_ctrl_pkg;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;

   localparam logic [1:0] EXC_NONE = 2'd0;
   localparam logic [1:0] EXC_ADDR = 2'd1;
   localparam logic [1:0] EXC_BUS  = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Half needs addr[0]=0; word (and the illegal code 3) needs addr[1:0]=0.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
      logic mis;
      case (size)
         SZ_B:    mis = 1'b0;
         SZ_H:    mis = off[0];
         default: mis = (off != 2'b00);
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/m_stage_mem_ctrl_if.sv
// Data-memory request/acknowledge bus between the M-stage controller and memory.
`timescale 1ns/1ps
interface m_stage_mem_ctrl_if #(
   parameter int ADDR_W = 32
);
   logic              bus_req;
   logic              bus_we;
   logic [ADDR_W-1:0] bus_addr;
   logic [3:0]        bus_be;
   logic [31:0]       bus_wdata;
   logic              bus_ack;
   logic [31:0]       bus_rdata;

   modport master (
      output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
      input  bus_ack, bus_rdata
   );

   modport slave (
      input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
      output bus_ack, bus_rdata
   );
endinterface

// File: rtl/m_stage_mem_ctrl_lane_align.sv
// Byte-lane helper: byte enables, store data replication, misalignment
// detection and load lane select with sign/zero extension. Purely combinational.
`timescale 1ns/1ps
module mem_lane_align
   import m_stage_mem_ctrl_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  off,
   input  logic        sign,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata,
   output logic [3:0]  be,
   output logic [31:0] wdata_lane,
   output logic        misaligned,
   output logic [31:0] rdata_ext
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Byte enables and store data replicated across the addressed lanes.
   always_comb begin
      be         = 4'b1111;
      wdata_lane = wdata;
      case (size)
         SZ_B: begin
            be         = 4'b0001 << off;
            wdata_lane = {4{wdata[7:0]}};
         end
         SZ_H: begin
            if (off[1]) begin
               be = 4'b1100;
            end else begin
               be = 4'b0011;
            end
            wdata_lane = {2{wdata[15:0]}};
         end
         default: begin
            be         = 4'b1111;
            wdata_lane = wdata;
         end
      endcase
   end

   // Pick the addressed lane of the read word and extend it to 32 bits.
   always_comb begin
      case (off)
         2'd0:    byte_sel = rdata[7:0];
         2'd1:    byte_sel = rdata[15:8];
         2'd2:    byte_sel = rdata[23:16];
         default: byte_sel = rdata[31:24];
      endcase
      if (off[1]) begin
         half_sel = rdata[31:16];
      end else begin
         half_sel = rdata[15:0];
      end
      case (size)
         SZ_B:    rdata_ext = {{24{sign & byte_sel[7]}}, byte_sel};
         SZ_H:    rdata_ext = {{16{sign & half_sel[15]}}, half_sel};
         default: rdata_ext = rdata;
      endcase
   end

   assign misaligned = is_misaligned(size, off);

endmodule

// File: rtl/m_stage_mem_ctrl.sv
// Memory-stage load/store controller: issues one data-memory access per M-stage
// instruction over the req/ack bus, stalls the pipeline until it finishes and
// reports the extended load data and any misalignment / bus-timeout exception.
`timescale 1ns/1ps
module m_stage_mem_ctrl
   import m_stage_mem_ctrl_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 64,
   parameter int ADDR_W         = 32
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      m_valid,
   input  logic                      m_we,
   input  logic [1:0]                m_size,
   input  logic                      m_sign,
   input  logic [31:0]               m_addr,
   input  logic [31:0]               m_wdata,
   input  logic                      flush,
   m_stage_mem_ctrl_if.master        bus,
   output logic                      mem_stall,
   output logic                      m_done,
   output logic [31:0]               m_rdata,
   output logic [1:0]                m_exc
);

   localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t            state, state_nx;
   logic              req, req_nx;
   logic              we, we_nx;
   logic [ADDR_W-1:0] addr, addr_nx;
   logic [3:0]        be, be_nx;
   logic [31:0]       wdata, wdata_nx;
   logic [31:0]       rdata_hold, rdata_nx;
   logic [1:0]        exc, exc_nx;
   logic              kill, kill_nx;
   logic [CNT_W-1:0]  tcnt, tcnt_nx;
   logic [1:0]        acc_size, acc_size_nx;
   logic [1:0]        acc_off, acc_off_nx;
   logic              acc_sign, acc_sign_nx;

   logic [1:0]        la_size;
   logic [1:0]        la_off;
   logic [3:0]        la_be;
   logic [31:0]       la_wdata;
   logic              la_mis;
   logic [31:0]       la_rdata;

   // While a request is outstanding the helper decodes the latched access
   // (for the read lane); otherwise it decodes the incoming instruction.
   assign la_size = (state == ST_REQ) ? acc_size : m_size;
   assign la_off  = (state == ST_REQ) ? acc_off  : m_addr[1:0];

   mem_lane_align u_lane (
      .size       (la_size),
      .off        (la_off),
      .sign       (acc_sign),
      .wdata      (m_wdata),
      .rdata      (bus.bus_rdata),
      .be         (la_be),
      .wdata_lane (la_wdata),
      .misaligned (la_mis),
      .rdata_ext  (la_rdata)
   );

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state and next-value logic for all registered outputs.
   always_comb begin
      state_nx    = state;
      req_nx      = req;
      we_nx       = we;
      addr_nx     = addr;
      be_nx       = be;
      wdata_nx    = wdata;
      rdata_nx    = rdata_hold;
      exc_nx      = exc;
      kill_nx     = kill;
      tcnt_nx     = tcnt;
      acc_size_nx = acc_size;
      acc_off_nx  = acc_off;
      acc_sign_nx = acc_sign;
      case (state)
         ST_IDLE: begin
            exc_nx  = EXC_NONE;
            kill_nx = 1'b0;
            tcnt_nx = '0;
            if (m_valid && !flush) begin
               if (la_mis) begin
                  state_nx = ST_DONE;
                  exc_nx   = EXC_ADDR;
               end else begin
                  state_nx    = ST_REQ;
                  req_nx      = 1'b1;
                  we_nx       = m_we;
                  addr_nx     = {m_addr[ADDR_W-1:2], 2'b00};
                  be_nx       = la_be;
                  wdata_nx    = la_wdata;
                  acc_size_nx = m_size;
                  acc_off_nx  = m_addr[1:0];
                  acc_sign_nx = m_sign;
               end
            end else begin
               state_nx = ST_IDLE;
            end
         end
         ST_REQ: begin
            // A flush cannot abort the bus cycle; it only marks the result dead.
            kill_nx = kill | flush;
            if (bus.bus_ack) begin
               state_nx = ST_DONE;
               req_nx   = 1'b0;
               tcnt_nx  = '0;
               exc_nx   = EXC_NONE;
               if (!kill && !flush && !we) begin
                  rdata_nx = la_rdata;
               end else begin
                  rdata_nx = rdata_hold;
               end
            end else if (tcnt == CNT_LAST) begin
               state_nx = ST_DONE;
               req_nx   = 1'b0;
               tcnt_nx  = '0;
               if (!kill && !flush) begin
                  exc_nx = EXC_BUS;
               end else begin
                  exc_nx = EXC_NONE;
               end
            end else begin
               tcnt_nx = tcnt + CNT_W'(1);
            end
         end
         ST_DONE: begin
            state_nx = ST_IDLE;
            exc_nx   = EXC_NONE;
            kill_nx  = 1'b0;
         end
         default: begin
            state_nx = ST_IDLE;
            req_nx   = 1'b0;
            exc_nx   = EXC_NONE;
            kill_nx  = 1'b0;
            tcnt_nx  = '0;
         end
      endcase
   end

   // Bus, result and bookkeeping registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         req        <= 1'b0;
         we         <= 1'b0;
         addr       <= '0;
         be         <= 4'b0000;
         wdata      <= 32'h0000_0000;
         rdata_hold <= 32'h0000_0000;
         exc        <= EXC_NONE;
         kill       <= 1'b0;
         tcnt       <= '0;
         acc_size   <= SZ_B;
         acc_off    <= 2'b00;
         acc_sign   <= 1'b0;
      end else begin
         req        <= req_nx;
         we         <= we_nx;
         addr       <= addr_nx;
         be         <= be_nx;
         wdata      <= wdata_nx;
         rdata_hold <= rdata_nx;
         exc        <= exc_nx;
         kill       <= kill_nx;
         tcnt       <= tcnt_nx;
         acc_size   <= acc_size_nx;
         acc_off    <= acc_off_nx;
         acc_sign   <= acc_sign_nx;
      end
   end

   assign bus.bus_req   = req;
   assign bus.bus_we    = we;
   assign bus.bus_addr  = addr;
   assign bus.bus_be    = be;
   assign bus.bus_wdata = wdata;

   // Stall is combinational so the next access can start right after DONE;
   // a flush landing in DONE still suppresses the completion pulse.
   assign mem_stall = m_valid & (state != ST_DONE);
   assign m_done    = (state == ST_DONE) & ~kill & ~flush;
   assign m_rdata   = rdata_hold;
   assign m_exc     = exc;

endmodule
